// File: rtl/spectrum_frame_collector.sv
// spectrum_frame_collector: deserialises a bin stream into a SIZE-entry frame published with a one-cycle load pulse
module spectrum_frame_collector #(
    parameter int SIZE  = 512,
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(SIZE)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    in_ready,
    input  logic                    out_hold,
    output logic [WIDTH*SIZE-1:0]   out_frame,
    output logic                    load,
    output logic [15:0]             frame_count,
    output logic                    err_sync
);
    typedef enum logic [1:0] {IDLE, FILL, PUBLISH} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shadow_q [SIZE];
    logic [WIDTH-1:0] shadow_d [SIZE];
    logic [WIDTH*SIZE-1:0] out_frame_q, out_frame_d;
    logic load_q, load_d, err_sync_q, err_sync_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic acc;
    assign in_ready    = state_q != PUBLISH;
    assign acc         = in_valid && in_ready;
    assign out_frame   = out_frame_q;
    assign load        = load_q;
    assign err_sync    = err_sync_q;
    assign frame_count = frame_count_q;
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        out_frame_d   = out_frame_q;
        frame_count_d = frame_count_q;
        load_d        = 1'b0;
        err_sync_d    = 1'b0;
        case (state_q)
            IDLE: if (acc) begin
                if (in_sof) begin
                    shadow_d[0] = in_data;
                    cnt_d       = CNT_W'(1);
                    state_d     = FILL;
                end else begin
                    err_sync_d = 1'b1;
                end
            end
            FILL: if (acc) begin
                if (in_sof) begin
                    err_sync_d  = 1'b1;
                    shadow_d[0] = in_data;
                    cnt_d       = CNT_W'(1);
                end else begin
                    shadow_d[cnt_q] = in_data;
                    cnt_d           = cnt_q + 1'b1;
                    state_d         = (cnt_q == CNT_W'(SIZE - 1)) ? PUBLISH : FILL;
                end
            end
            PUBLISH: if (!out_hold) begin
                for (int k = 0; k < SIZE; k++) out_frame_d[k*WIDTH +: WIDTH] = shadow_q[k];
                load_d        = 1'b1;
                frame_count_d = frame_count_q + 16'd1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            out_frame_q   <= '0;
            load_q        <= 1'b0;
            err_sync_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            out_frame_q   <= out_frame_d;
            load_q        <= load_d;
            err_sync_q    <= err_sync_d;
            frame_count_q <= frame_count_d;
        end
    end
    always_ff @(posedge clk) shadow_q <= shadow_d;
endmodule

// File: tb/tb_spectrum_frame_collector.sv
// tb_spectrum_frame_collector: randomized scenarios checked against a queue-based frame model
module tb_spectrum_frame_collector;
    localparam int SIZE  = 512;
    localparam int WIDTH = 16;
    localparam int FW    = WIDTH * SIZE;

    logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_sof = 1'b0, out_hold = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic in_ready, load, err_sync;
    logic [FW-1:0] out_frame;
    logic [15:0] frame_count;

    spectrum_frame_collector #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .in_ready(in_ready), .out_hold(out_hold), .out_frame(out_frame), .load(load),
        .frame_count(frame_count), .err_sync(err_sync)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0, fails = 0;
    int load_cyc[$];
    logic [FW-1:0] snaps[$];
    int err_cnt = 0, bad_change = 0;
    logic [FW-1:0] prev_frame;
    always @(negedge clk) begin
        if (load) begin
            load_cyc.push_back(cyc);
            snaps.push_back(out_frame);
        end
        if (err_sync) err_cnt++;
        if (!reset && !load && out_frame !== prev_frame) bad_change++;
        prev_frame = out_frame;
    end

    logic [WIDTH-1:0] stim_d[$];
    logic stim_s[$];
    logic [FW-1:0] exp_frames[$];
    int exp_err, last_acc, lb, eb, cb;
    bit rand_hold = 0;

    function automatic int first_diff(input logic [FW-1:0] a, input logic [FW-1:0] b);
        for (int k = 0; k < SIZE; k++) if (a[k*WIDTH +: WIDTH] !== b[k*WIDTH +: WIDTH]) return k;
        return -1;
    endfunction

    task automatic mark();
        lb = load_cyc.size();
        eb = err_cnt;
        cb = bad_change;
    endtask

    task automatic apply_reset();
        reset = 1'b1; in_valid = 1'b0; out_hold = 1'b0; rand_hold = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic sof, input int gap);
        logic rdy;
        repeat (gap) begin
            @(posedge clk); #1;
            if (rand_hold) out_hold = ($urandom_range(0, 3) == 0);
        end
        in_valid = 1'b1; in_sof = sof; in_data = d;
        for (int t = 0; ; t++) begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (rand_hold) out_hold = ($urandom_range(0, 3) == 0);
            if (rdy) break;
            if (t > 1000) begin
                fails++;
                $display("FAIL send_timeout in_ready stayed 0 for %0d cycles, required 1", t);
                break;
            end
        end
        last_acc = cyc;
        in_valid = 1'b0; in_sof = 1'($urandom); in_data = 16'($urandom);
    endtask

    // Reference: bins since the last sof form the frame; SIZE of them make a published frame.
    task automatic play(input int gmax);
        logic [WIDTH-1:0] cur[$];
        logic [FW-1:0] ev;
        exp_frames.delete();
        exp_err = 0;
        foreach (stim_d[i]) begin
            if (stim_s[i]) begin
                if (cur.size() > 0) exp_err++;
                cur.delete();
                cur.push_back(stim_d[i]);
            end else if (cur.size() == 0) exp_err++;
            else cur.push_back(stim_d[i]);
            if (cur.size() == SIZE) begin
                for (int k = 0; k < SIZE; k++) ev[k*WIDTH +: WIDTH] = cur[k];
                exp_frames.push_back(ev);
                cur.delete();
            end
        end
        foreach (stim_d[i]) send(stim_d[i], stim_s[i], $urandom_range(0, gmax));
        rand_hold = 0;
        out_hold = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_frames(input string name);
        int n;
        n = load_cyc.size() - lb;
        vectors++;
        if (n !== exp_frames.size()) begin
            fails++;
            $display("FAIL %s load_count got %0d want %0d", name, n, exp_frames.size());
        end
        for (int i = 0; i < n && i < exp_frames.size(); i++) begin
            vectors++;
            if (snaps[lb+i] !== exp_frames[i]) begin
                fails++;
                $display("FAIL %s frame%0d bin %0d differs", name, i, first_diff(snaps[lb+i], exp_frames[i]));
            end
        end
        vectors++;
        if (err_cnt - eb !== exp_err) begin
            fails++;
            $display("FAIL %s err_sync_pulses got %0d want %0d", name, err_cnt - eb, exp_err);
        end
        vectors++;
        if (frame_count !== 16'(exp_frames.size())) begin
            fails++;
            $display("FAIL %s frame_count got %0d want %0d", name, frame_count, exp_frames.size());
        end
        vectors++;
        if (bad_change - cb !== 0) begin
            fails++;
            $display("FAIL %s out_frame_changed_without_load got %0d want 0", name, bad_change - cb);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset in_ready got %b want 1", in_ready); end
        vectors++; if (load !== 1'b0) begin fails++; $display("FAIL reset load got %b want 0", load); end
        vectors++; if (err_sync !== 1'b0) begin fails++; $display("FAIL reset err_sync got %b want 0", err_sync); end
        vectors++; if (frame_count !== 16'd0) begin fails++; $display("FAIL reset frame_count got %0d want 0", frame_count); end
        vectors++; if (out_frame !== '0) begin fails++; $display("FAIL reset out_frame nonzero at bin %0d", first_diff(out_frame, '0)); end
    endtask

    task automatic test_single_frame();
        apply_reset(); mark();
        stim_d.delete(); stim_s.delete();
        for (int k = 0; k < SIZE; k++) begin stim_d.push_back(16'(k)); stim_s.push_back(k == 0); end
        play(0);
        check_frames("single");
        vectors++;
        if (load_cyc.size() > lb && load_cyc[lb] !== last_acc + 1) begin
            fails++;
            $display("FAIL single load_latency got edge %0d want %0d", load_cyc[lb], last_acc + 1);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset(); mark();
        stim_d.delete(); stim_s.delete();
        for (int k = 0; k < SIZE; k++) begin stim_d.push_back(16'hA000 + 16'(k)); stim_s.push_back(k == 0); end
        for (int k = 0; k < SIZE; k++) begin stim_d.push_back(16'hB000 + 16'(k)); stim_s.push_back(k == 0); end
        play(0);
        check_frames("back_to_back");
        vectors++;
        if (load_cyc.size() >= lb + 2 && load_cyc[lb+1] - load_cyc[lb] !== SIZE + 1) begin
            fails++;
            $display("FAIL back_to_back load_spacing got %0d want %0d", load_cyc[lb+1] - load_cyc[lb], SIZE + 1);
        end
    endtask

    task automatic test_hold();
        logic [FW-1:0] ev;
        logic [WIDTH-1:0] d;
        apply_reset(); mark();
        for (int k = 0; k < SIZE; k++) begin
            d = 16'($urandom);
            ev[k*WIDTH +: WIDTH] = d;
            if (k == SIZE - 1) out_hold = 1'b1;
            send(d, k == 0, 0);
        end
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (in_ready !== 1'b0 || load !== 1'b0) begin
                fails++;
                $display("FAIL hold cycle%0d in_ready/load got %b/%b want 0/0", i, in_ready, load);
            end
            @(posedge clk); #1;
        end
        out_hold = 1'b0;
        @(posedge clk); #1;
        vectors++; if (load !== 1'b1) begin fails++; $display("FAIL hold_release load got %b want 1", load); end
        vectors++; if (out_frame !== ev) begin fails++; $display("FAIL hold_release out_frame bin %0d differs", first_diff(out_frame, ev)); end
        vectors++; if (frame_count !== 16'd1) begin fails++; $display("FAIL hold_release frame_count got %0d want 1", frame_count); end
        @(posedge clk); #1;
        vectors++; if (load !== 1'b0) begin fails++; $display("FAIL hold_pulse_width load got %b want 0", load); end
    endtask

    task automatic test_no_sof();
        apply_reset(); mark();
        stim_d.delete(); stim_s.delete();
        for (int k = 0; k < 3; k++) begin stim_d.push_back(16'($urandom)); stim_s.push_back(1'b0); end
        for (int k = 0; k < SIZE; k++) begin stim_d.push_back(16'($urandom)); stim_s.push_back(k == 0); end
        play(0);
        check_frames("no_sof");
    endtask

    task automatic test_short_frame();
        apply_reset(); mark();
        stim_d.delete(); stim_s.delete();
        for (int k = 0; k < 100; k++) begin stim_d.push_back(16'($urandom)); stim_s.push_back(k == 0); end
        for (int k = 0; k < SIZE; k++) begin stim_d.push_back(16'h1234); stim_s.push_back(k == 0); end
        play(1);
        check_frames("short_frame");
        vectors++;
        if (out_frame !== {SIZE{16'h1234}}) begin
            fails++;
            $display("FAIL short_frame out_frame bin %0d not 1234", first_diff(out_frame, {SIZE{16'h1234}}));
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int k = 0; k < 300; k++) send(16'($urandom), k == 0, 0);
        mark();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        vectors++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_mid in_ready got %b want 1", in_ready); end
        vectors++; if (frame_count !== 16'd0) begin fails++; $display("FAIL reset_mid frame_count got %0d want 0", frame_count); end
        vectors++; if (out_frame !== '0) begin fails++; $display("FAIL reset_mid out_frame bin %0d nonzero", first_diff(out_frame, '0)); end
        repeat (3) @(posedge clk);
        #1;
        stim_d.delete(); stim_s.delete();
        for (int k = 0; k < SIZE; k++) begin stim_d.push_back(16'($urandom)); stim_s.push_back(k == 0); end
        play(0);
        check_frames("reset_mid");
    endtask

    task automatic test_random();
        apply_reset(); mark();
        stim_d.delete(); stim_s.delete();
        for (int f = 0; f < 6; f++) begin
            int len;
            len = ($urandom_range(0, 9) < 7) ? SIZE : $urandom_range(1, SIZE - 1);
            repeat ($urandom_range(0, 2)) begin stim_d.push_back(16'($urandom)); stim_s.push_back(1'b0); end
            for (int k = 0; k < len; k++) begin stim_d.push_back(16'($urandom)); stim_s.push_back(k == 0); end
        end
        rand_hold = 1;
        play(2);
        check_frames("random");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_hold();
        test_no_sof();
        test_short_frame();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
